mul_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers for the MIPS32 core.
- Replaces the single-cycle HI/LO write path.
- Executes MULT/MULTU/DIV/DIVU as a radix-2 multi-cycle shift-add / restoring-divide engine.
- Executes MTHI/MTLO in one cycle; provides busy to the core for stalling MFHI/MFLO and further HI/LO ops.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_sign_fix.sv | 32 +++
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit (mul_div_unit).
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Iteration counter must hold 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Converts the unsigned magnitude result of a multiply or divide into the signed HI/LO pair.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mag_hi_i,
  input  logic [WIDTH-1:0] mag_lo_i,
  input  logic             mul_i,
  input  logic             neg_p_i,
  input  logic             neg_r_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_neg;

  assign prod_mag = {mag_hi_i, mag_lo_i};
  assign prod_neg = -prod_mag;

  // Multiply negates the full double-width product; divide fixes quotient and remainder separately.
  always_comb begin
    hi_o = mag_hi_i;
    lo_o = mag_lo_i;
    if (mul_i) begin
      {hi_o, lo_o} = neg_p_i ? prod_neg : prod_mag;
    end else begin
      hi_o = neg_r_i ? -mag_hi_i : mag_hi_i;
      lo_o = neg_p_i ? -mag_lo_i : mag_lo_i;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO complete in one cycle.
// Optional MDU_DIV0_EN: divide-by-zero short-cuts to FINISH and raises the sticky div0 output.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             mul_q, mul_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;
  logic             done_q, done_d;
`ifdef MDU_DIV0_EN
  logic             dz_q, dz_d;
  logic             div0_q, div0_d;
`endif

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [W2-1:0]    mul_next, div_next;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand to upper half on LSB, then shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; shift left, trial-subtract, restore on borrow.
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mag_hi_i (acc_q[W2-1:WIDTH]),
    .mag_lo_i (acc_q[WIDTH-1:0]),
    .mul_i    (mul_q),
    .neg_p_i  (neg_p_q),
    .neg_r_i  (neg_r_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_d   = mul_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    done_d  = 1'b0;
`ifdef MDU_DIV0_EN
    dz_d    = dz_q;
    div0_d  = div0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = ST_CALC;
              cnt_d   = '0;
              mul_d   = ~op[1];
              opnd_d  = op[1] ? b_mag : a_mag;
              acc_d   = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              neg_p_d = a_neg ^ b_neg;
              neg_r_d = a_neg;
`ifdef MDU_DIV0_EN
              div0_d = 1'b0;
              dz_d   = op[1] && (b == '0);
              if (op[1] && (b == '0)) state_d = ST_FINISH;
`endif
            end
            OP_MTHI: begin
              hi_d = a;
`ifdef MDU_DIV0_EN
              div0_d = 1'b0;
`endif
            end
            OP_MTLO: begin
              lo_d = a;
`ifdef MDU_DIV0_EN
              div0_d = 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = mul_q ? mul_next : div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
`ifdef MDU_DIV0_EN
          if (dz_q) begin
            div0_d = 1'b1;
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
`else
          hi_d = fix_hi;
          lo_d = fix_lo;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV0_EN
      dz_q    <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_q   <= mul_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      done_q  <= done_d;
`ifdef MDU_DIV0_EN
      dz_q    <= dz_d;
      div0_q  <= div0_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIV0_EN
  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit at WIDTH=32, plus hand-written corner sequences.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIV0_EN
  logic        div0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  mul_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MDU_DIV0_EN
    ,
    .div0  (div0)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one multi-cycle op and check result, busy length and a single done pulse.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                        input int exp_busy);
    int cyc;
    int dn;
    @(negedge clock);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dn++;
      @(negedge clock);
    end
    if (done) dn++;
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " busy_cycles"}, 64'(cyc), 64'(exp_busy));
    @(negedge clock);
    if (done) dn++;
    chk({nm, " done_pulses"}, 64'(dn), 64'd1);
    $display("txn %s op=%b a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", nm, o, va, vb, hi, lo, cyc);
  endtask

  initial begin
    int dn;
    vecs[0] = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{3'b001, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[2] = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[9] = '{3'b011, 32'h0000FFFF, 32'h00000100, 32'h000000FF, 32'h000000FF};

    // Reset held with a pending start: nothing may move.
    start = 1'b1; op = 3'b000; a = 32'h11111111; b = 32'h22222222;
    repeat (4) @(negedge clock);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    $display("txn reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 33);
    end

    // MTHI then MTLO back to back: one-cycle writes, busy never rises.
    @(negedge clock);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clock);
    chk("mthi hi", 64'(hi), 64'h12345678);
    chk("mthi busy", 64'(busy), 64'd0);
    op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clock);
    start = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);
    $display("txn mthi/mtlo: hi=%h lo=%h", hi, lo);

    // MULT, ignored MTLO at cycle 5, flush at cycle 10.
    @(negedge clock);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    @(negedge clock);
    start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done) dn++;
      if (c == 5) begin start = 1'b1; op = 3'b101; a = 32'h0; end
      else start = 1'b0;
      if (c == 10) flush = 1'b1;
      @(negedge clock);
    end
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (done) dn++;
      @(negedge clock);
    end
    chk("flush hi", 64'(hi), 64'h12345678);
    chk("flush lo", 64'(lo), 64'h9ABCDEF0);
    chk("flush done_pulses", 64'(dn), 64'd0);
    $display("txn flush: hi=%h lo=%h done_pulses=%0d", hi, lo, dn);

    // Start and flush together in IDLE: start wins.
    @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    chk("startflush busy", 64'(busy), 64'd1);
    for (int c = 0; c < 40 && busy; c++) @(negedge clock);
    chk("startflush hi", 64'(hi), 64'd0);
    chk("startflush lo", 64'(lo), 64'd15);
    $display("txn start+flush: hi=%h lo=%h", hi, lo);
    @(negedge clock);

`ifdef MDU_DIV0_EN
    run_op("divu0", 3'b011, 32'd5, 32'd0, 32'd0, 32'd15, 1);
    chk("div0 set", 64'(div0), 64'd1);
    @(negedge clock);
    start = 1'b1; op = 3'b100; a = 32'hAAAA5555;
    @(negedge clock);
    start = 1'b0;
    chk("div0 cleared", 64'(div0), 64'd0);
    chk("div0 mthi hi", 64'(hi), 64'hAAAA5555);
    $display("txn mthi after div0: hi=%h div0=%b", hi, div0);
`else
    run_op("divu0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
    run_op("div0neg", 3'b010, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'd1, 33);
    @(negedge clock);
    start = 1'b1; op = 3'b100; a = 32'hAAAA5555;
    @(negedge clock);
    start = 1'b0;
    chk("mthi2 hi", 64'(hi), 64'hAAAA5555);
`endif

    // Asynchronous reset at cycle 10 of a MULT.
    @(negedge clock);
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dn++;
      @(negedge clock);
    end
    chk("midreset done_pulses", 64'(dn), 64'd0);
    chk("midreset lo after", 64'(lo), 64'd0);
    $display("txn midreset: hi=%h lo=%h busy=%b done_pulses=%0d", hi, lo, busy, dn);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
